id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register plus load-use hazard control. Captures decoded operands/controls each cycle
//  and presents them to EX and to the operand-forwarding unit (ex_rs1_sel, ex_op1_msel, ex_op1_def, ...).
//  Detects a load in EX feeding the instruction in ID and inserts exactly one bubble, holding PC and IF/ID.
// PARAMETERS
//  XLEN    32  datapath width
//  REG_AW  5   register-index width
// PORTS
//  clk                 in   1       clock, all state updates on rising edge
//  rst                 in   1       synchronous reset, active-high
//  id_valid            in   1       ID holds a real instruction
//  id_rs1_sel/rs2_sel  in   REG_AW  source register indices
//  id_rs1_used/rs2_used in  1       instruction reads rs1 / rs2 (consumed by the ALU)
//  id_rd_sel           in   REG_AW  destination index
//  id_reg_wr_en        in   1       writes rd
//  id_reg_wr_mux_sel   in   3       writeback source: 0 ALU, 1..5 load variants
//  id_op1_msel/op2_msel in  3       default operand mux selects
//  id_op1_def/op2_def  in   1       forwarding-disable flags, passed through unchanged
//  id_dmem_wr_en       in   1       store
//  id_alu_op           in   4       ALU opcode
//  id_pc, id_imm, id_rs1_data, id_rs2_data  in  XLEN  operand payload
//  ex_flush            in   1       taken branch/jump resolved in EX; kill ID
//  mem_stall           in   1       downstream memory stall; freeze stage
//  ex_*                out  (same)  registered copy of every id_* input above, plus ex_valid
//  stall_if_id         out  1       hold PC and IF/ID this cycle
//  `HAZ_PERF_CNT_EN: stall_cnt, flush_cnt  out  32  event counters
// BEHAVIOUR
//  - Reset: all ex_* = 0 (bubble: ex_valid=0, ex_reg_wr_en=0, ex_dmem_wr_en=0), state=RUN, counters=0.
//  - Latency: 1 cycle, id_* at edge N -> ex_* after edge N.
//  - ex_load = ex_valid & ex_reg_wr_en & ex_reg_wr_mux_sel in 1..5 & ex_rd_sel != 0.
//  - hazard = id_valid & ex_load & ((id_rs1_used & id_rs1_sel==ex_rd_sel) | (id_rs2_used & id_rs2_sel==ex_rd_sel)).
//    Store-data-only dependency (id_dmem_wr_en, rs2 not ALU-used) is NOT a hazard; forwarding handles it.
//  - FSM RUN: hazard -> load bubble into ID/EX, stall_if_id=1, go LU_STALL; else capture id_*.
//  - FSM LU_STALL: capture id_* unconditionally (load now in EX/MEM, forwarded), stall_if_id=0, go RUN.
//    Guarantees at most one bubble per load; back-to-back loads each evaluated independently.
//  - Priority per cycle: rst > mem_stall > ex_flush > hazard > normal.
//  - mem_stall=1: all ex_* hold, state holds, stall_if_id=1, no counter change.
//  - ex_flush=1 (no mem_stall): bubble loaded, state->RUN, stall_if_id=0; flush wins over hazard.
//  - Bubble zeroes ex_valid/ex_reg_wr_en/ex_dmem_wr_en; other fields don't-care but driven 0.
//  - stall_if_id is combinational from state/inputs; all ex_* are pure flops.
//  - rd=x0 never triggers a stall.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: stall_cnt += 1 per hazard-bubble cycle, flush_cnt += 1 per ex_flush cycle
//   (not during mem_stall); 32-bit wrap-around; reset to 0.
//  Undefined: counter ports and logic absent; all other behaviour identical.
// STRUCTURE
//  cpu_pkg: wb_sel_e (WB_ALU=0, WB_LB..WB_LHU=1..5), idex_t packed struct of all ex_* fields,
//   IDEX_BUBBLE constant, haz_state_e {RUN, LU_STALL}.
//  Sub-module load_use_detect (combinational: ex_* + id srcs -> hazard); one idex_t register here.
// TESTING
//  1 Load x5 then ADD x6,x5,x7 (rs1_used) -> one bubble (ex_valid=0), stall_if_id=1 for 1 cycle, ADD in EX next.
//  2 Load x5 then SW with x5 as store data only -> no stall, SW captured next cycle.
//  3 Load x0 then ADD using x0 -> no stall.
//  4 Hazard cycle with ex_flush=1 -> bubble, stall_if_id=0, state RUN; flush_cnt=1 when HAZ_PERF_CNT_EN.
//  5 mem_stall=1 for 3 cycles mid-LU_STALL -> ex_* frozen, stall_if_id=1, resumes to capture then RUN.
//  6 rst asserted in LU_STALL -> next cycle all ex_*=0, state RUN, counters 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the ID/EX stage.
//   wb_sel_e    : writeback source select (0 ALU, 1..5 load variants)
//   haz_state_e : load-use control state
//   idex_t      : every field held in the ID/EX register
//   IDEX_BUBBLE : all-zero register value (no valid instruction, no side effects)
//   is_load     : true when a writeback select names a memory load
package cpu_pkg;

    localparam int unsigned CPU_XLEN   = 32;
    localparam int unsigned CPU_REG_AW = 5;

    typedef enum logic [2:0] {
        WB_ALU = 3'd0,
        WB_LB  = 3'd1,
        WB_LH  = 3'd2,
        WB_LW  = 3'd3,
        WB_LBU = 3'd4,
        WB_LHU = 3'd5
    } wb_sel_e;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } haz_state_e;

    typedef struct packed {
        logic                  valid;
        logic [CPU_XLEN-1:0]   pc;
        logic [CPU_XLEN-1:0]   imm;
        logic [CPU_XLEN-1:0]   rs1_data;
        logic [CPU_XLEN-1:0]   rs2_data;
        logic [CPU_REG_AW-1:0] rs1_sel;
        logic [CPU_REG_AW-1:0] rs2_sel;
        logic                  rs1_used;
        logic                  rs2_used;
        logic [CPU_REG_AW-1:0] rd_sel;
        logic                  reg_wr_en;
        logic [2:0]            reg_wr_mux_sel;
        logic [2:0]            op1_msel;
        logic [2:0]            op2_msel;
        logic                  op1_def;
        logic                  op2_def;
        logic                  dmem_wr_en;
        logic [3:0]            alu_op;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '0;

    function automatic logic is_load(input logic [2:0] sel);
        return (sel >= WB_LB) && (sel <= WB_LHU);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
//   Inputs : ID source indices/usage flags, EX valid/write-enable/writeback select/rd.
//   Output : hazard -- the instruction in ID reads, through the ALU, the register
//            a load in EX has not yet returned.
// Store data (rs2 not ALU-used) is left to forwarding and never raises hazard.
module load_use_detect
    import cpu_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_sel,
    input  logic              id_rs1_used,
    input  logic [REG_AW-1:0] id_rs2_sel,
    input  logic              id_rs2_used,
    input  logic              ex_valid,
    input  logic              ex_reg_wr_en,
    input  logic [2:0]        ex_reg_wr_mux_sel,
    input  logic [REG_AW-1:0] ex_rd_sel,
    output logic              hazard
);

    logic ex_load;
    logic rs1_dep;
    logic rs2_dep;

    always_comb begin
        // rd = x0 is never actually written, so it cannot create a dependency.
        ex_load = ex_valid && ex_reg_wr_en && is_load(ex_reg_wr_mux_sel) && (ex_rd_sel != '0);
        rs1_dep = id_rs1_used && (id_rs1_sel == ex_rd_sel);
        rs2_dep = id_rs2_used && (id_rs2_sel == ex_rd_sel);
        hazard  = id_valid && ex_load && (rs1_dep || rs2_dep);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard control.
//   clk, rst          : clock, synchronous active-high reset
//   id_*              : decoded instruction fields from ID
//   ex_flush          : taken branch/jump in EX; the ID instruction is killed
//   mem_stall         : downstream stall; the whole stage freezes
//   ex_*              : registered copy of the id_* fields plus ex_valid
//   stall_if_id       : hold PC and IF/ID this cycle
//   stall_cnt/flush_cnt (only with HAZ_PERF_CNT_EN defined): 32-bit event counters
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_sel,
    input  logic [REG_AW-1:0] id_rs2_sel,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd_sel,
    input  logic              id_reg_wr_en,
    input  logic [2:0]        id_reg_wr_mux_sel,
    input  logic [2:0]        id_op1_msel,
    input  logic [2:0]        id_op2_msel,
    input  logic              id_op1_def,
    input  logic              id_op2_def,
    input  logic              id_dmem_wr_en,
    input  logic [3:0]        id_alu_op,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic              ex_flush,
    input  logic              mem_stall,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_rs1_sel,
    output logic [REG_AW-1:0] ex_rs2_sel,
    output logic              ex_rs1_used,
    output logic              ex_rs2_used,
    output logic [REG_AW-1:0] ex_rd_sel,
    output logic              ex_reg_wr_en,
    output logic [2:0]        ex_reg_wr_mux_sel,
    output logic [2:0]        ex_op1_msel,
    output logic [2:0]        ex_op2_msel,
    output logic              ex_op1_def,
    output logic              ex_op2_def,
    output logic              ex_dmem_wr_en,
    output logic [3:0]        ex_alu_op,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic              stall_if_id
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    haz_state_e state_q, state_d;
    idex_t      idex_q, idex_d, id_word;
    logic       hazard;
    logic       stall_evt;
    logic       flush_evt;

    load_use_detect #(.REG_AW(REG_AW)) u_lud (
        .id_valid          (id_valid),
        .id_rs1_sel        (id_rs1_sel),
        .id_rs1_used       (id_rs1_used),
        .id_rs2_sel        (id_rs2_sel),
        .id_rs2_used       (id_rs2_used),
        .ex_valid          (idex_q.valid),
        .ex_reg_wr_en      (idex_q.reg_wr_en),
        .ex_reg_wr_mux_sel (idex_q.reg_wr_mux_sel),
        .ex_rd_sel         (idex_q.rd_sel),
        .hazard            (hazard)
    );

    always_comb begin
        id_word                = IDEX_BUBBLE;
        id_word.valid          = id_valid;
        id_word.pc             = id_pc;
        id_word.imm            = id_imm;
        id_word.rs1_data       = id_rs1_data;
        id_word.rs2_data       = id_rs2_data;
        id_word.rs1_sel        = id_rs1_sel;
        id_word.rs2_sel        = id_rs2_sel;
        id_word.rs1_used       = id_rs1_used;
        id_word.rs2_used       = id_rs2_used;
        id_word.rd_sel         = id_rd_sel;
        id_word.reg_wr_en      = id_reg_wr_en;
        id_word.reg_wr_mux_sel = id_reg_wr_mux_sel;
        id_word.op1_msel       = id_op1_msel;
        id_word.op2_msel       = id_op2_msel;
        id_word.op1_def        = id_op1_def;
        id_word.op2_def        = id_op2_def;
        id_word.dmem_wr_en     = id_dmem_wr_en;
        id_word.alu_op         = id_alu_op;
    end

    // Priority: mem_stall > ex_flush > hazard > normal capture.
    always_comb begin
        state_d     = state_q;
        idex_d      = idex_q;
        stall_if_id = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        if (mem_stall) begin
            stall_if_id = 1'b1;
        end else if (ex_flush) begin
            idex_d    = IDEX_BUBBLE;
            state_d   = RUN;
            flush_evt = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hazard) begin
                        idex_d      = IDEX_BUBBLE;
                        stall_if_id = 1'b1;
                        stall_evt   = 1'b1;
                        state_d     = LU_STALL;
                    end else begin
                        idex_d = id_word;
                    end
                end
                LU_STALL: begin
                    // The load has moved on and is forwardable: capture without re-checking.
                    idex_d  = id_word;
                    state_d = RUN;
                end
                default: begin
                    idex_d  = IDEX_BUBBLE;
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            idex_q  <= IDEX_BUBBLE;
        end else begin
            state_q <= state_d;
            idex_q  <= idex_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt) stall_cnt <= stall_cnt + 32'd1;
            if (flush_evt) flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

    assign ex_valid          = idex_q.valid;
    assign ex_pc             = idex_q.pc;
    assign ex_imm            = idex_q.imm;
    assign ex_rs1_data       = idex_q.rs1_data;
    assign ex_rs2_data       = idex_q.rs2_data;
    assign ex_rs1_sel        = idex_q.rs1_sel;
    assign ex_rs2_sel        = idex_q.rs2_sel;
    assign ex_rs1_used       = idex_q.rs1_used;
    assign ex_rs2_used       = idex_q.rs2_used;
    assign ex_rd_sel         = idex_q.rd_sel;
    assign ex_reg_wr_en      = idex_q.reg_wr_en;
    assign ex_reg_wr_mux_sel = idex_q.reg_wr_mux_sel;
    assign ex_op1_msel       = idex_q.op1_msel;
    assign ex_op2_msel       = idex_q.op2_msel;
    assign ex_op1_def        = idex_q.op1_def;
    assign ex_op2_def        = idex_q.op2_def;
    assign ex_dmem_wr_en     = idex_q.dmem_wr_en;
    assign ex_alu_op         = idex_q.alu_op;

endmodule
